bless_inject_ctrl: RTL and testbench
====================================

# bless_inject_ctrl

Local-port injection controller for the bufferless BLESS router. It sits between the local core and the router's `dinLocal` input. It queues core flits in a small FIFO and stamps the 8-bit TIME field used for oldest-first arbitration. It injects a flit only in cycles where the four network inputs leave at least one output free, and it flags injection starvation.

## Interface
Parameters:
- `WIDTH_PORT`, default `` `WIDTH_PORT ``: flit width, with layout {PKTID 6, FLITID 2, TIME 8, POS_X 4, POS_Y 4, DATA `WIDTH_DATA`}.
- `FIFO_DEPTH`, default 4: injection queue entries (power of 2).
- `STARVE_LIMIT`, default 16: consecutive blocked cycles before `starve` asserts.
- `INJ_GAP`, default 2: idle cycles enforced after each injection (throttle build only).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `coreFlit`, in, WIDTH_PORT: flit from core.
- `coreValid`, in, 1: `coreFlit` valid.
- `coreReady`, out, 1: FIFO can accept.
- `dinW`, `dinE`, `dinS`, `dinN`, in, WIDTH_PORT each: the router's network inputs, observed in the same cycle the router samples them.
- `dinLocal`, out, WIDTH_PORT: flit to router local input. All-zero means no flit.
- `injFire`, out, 1: a flit is on `dinLocal` this cycle.
- `starve`, out, 1: head flit blocked ≥ STARVE_LIMIT cycles.
- `fifoCount`, out, log2(FIFO_DEPTH)+1: queue occupancy.

## Operation
- A port word equal to zero is an idle slot. Network occupancy `occ` is the number of non-zero words among dinW/E/S/N (range 0–4).
- Push occurs when `coreValid & coreReady`. `coreReady = (fifoCount != FIFO_DEPTH)`. An all-zero `coreFlit` is accepted and discarded: no push, count unchanged.
- Timestamp `tstamp` is an 8-bit free-running counter. It increments every cycle and wraps 255→0.
- Eligibility: `elig = head present & occ < 4 & state != HOLD`.
- `dinLocal` is combinational: `elig ? stamped head : 0`. `injFire = elig`. The head is popped at the clock edge when `elig` is high.
- Stamping:
  - FLITID==0: TIME field [WIDTH_DATA+15:WIDTH_DATA+8] is replaced by the current `tstamp`, and the value is saved in `pktStamp`.
  - FLITID≠0: TIME is replaced by `pktStamp`, so all flits of a packet share one age.
  - All other fields pass through unchanged.
- State machine:
  - EMPTY: FIFO empty. Goes to WAIT on push.
  - WAIT: head present.
    - On injection: go to EMPTY if the FIFO becomes empty, else stay in WAIT. In the throttle build, go to HOLD instead.
    - When blocked (occ==4): increment `blockCnt`, which saturates at STARVE_LIMIT.
  - HOLD (throttle build only): `gapCnt` counts INJ_GAP cycles. Then go to WAIT if the head is present, else EMPTY.
- `starve = (blockCnt == STARVE_LIMIT)`. `blockCnt` clears on injection. It holds its value in HOLD and EMPTY.
- Simultaneous push and pop: count unchanged. A push into an empty FIFO is not injectable in the same cycle.

## Timing
- Reset values:
  - `dinLocal`=0, `injFire`=0, `starve`=0, `fifoCount`=0.
  - `coreReady`=1, `tstamp`=0, `pktStamp`=0, `blockCnt`=0, state EMPTY.
- Reset asserted mid-operation flushes the queue immediately. In-flight flits are lost, and `dinLocal` goes to 0 asynchronously.
- Latency: a flit pushed at edge t can appear on `dinLocal` in cycle t+1 at earliest, if occ<4.
- Throughput: 1 flit/cycle. In the throttle build the maximum is 1 flit per INJ_GAP+1 cycles.
- `dinLocal` depends combinationally on `dinW/E/S/N`. This is the only combinational input-to-output path.
- A full FIFO deasserts `coreReady` in the same cycle `fifoCount` reaches FIFO_DEPTH. `coreReady` reasserts the cycle after a pop.

## Configuration
- `BLESS_THROTTLE_EN`:
  - Defined: HOLD state and INJ_GAP spacing are active.
  - Undefined: HOLD is never entered, `gapCnt` logic is removed, and injection may occur every eligible cycle.
- All ports exist in both builds.

## Test plan
- Reset, then push A (FLITID 0) at `tstamp`=5 with occ=0. Expect `dinLocal`=A with TIME=6 in the next cycle, `injFire`=1, then `dinLocal`=0.
- Hold occ=4 (four non-zero inputs), push one flit, and keep occ=4 for 20 cycles. Expect `starve`=1 from the 16th blocked cycle. Then drop dinN to 0 and expect injection that cycle and `starve`=0 the next cycle.
- Push packet flits FLITID 0,1,2,3 back-to-back with occ=3 while `tstamp` passes 254→1. Expect all four injected with TIME=pktStamp of flit 0.
- Fill the FIFO (4 pushes) with occ=4. Expect `coreReady`=0 and `fifoCount`=4. Release occ to 2 and expect one pop per cycle, with `coreReady`=1 after the first pop.
- With `BLESS_THROTTLE_EN`, occ=0, and 3 queued flits: expect injections at cycles t, t+3, t+6. Without the macro, expect t, t+1, t+2.
- Assert `reset` with 2 flits queued. Expect `fifoCount`=0 and `dinLocal`=0 immediately.

Source files
------------

// File: rtl/bless_inject_ctrl.sv
// ---------------------------------------------------------------------------
// bless_inject_ctrl
//
// Local-port injection controller for the bufferless BLESS router. Core flits
// are queued in a small FIFO. The head flit is offered to the router's local
// input only in cycles where the four network inputs leave an output free.
// The 8-bit TIME field is stamped so that all flits of one packet share the
// age of their head flit (FLITID 0).
//
// Flit layout (MSB..LSB): {PKTID 6, FLITID 2, TIME 8, POS_X 4, POS_Y 4, DATA}
//
// Build option:
//   BLESS_THROTTLE_EN - when defined, each injection is followed by INJ_GAP
//                       idle cycles (HOLD state). When undefined, HOLD is
//                       never entered and the gap counter does not exist.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   coreFlit   in   flit from core (all-zero words are dropped)
//   coreValid  in   coreFlit valid
//   coreReady  out  FIFO can accept a flit
//   dinW/E/S/N in   router network inputs, as sampled by the router
//   dinLocal   out  stamped head flit when injecting, else zero
//   injFire    out  a flit is on dinLocal this cycle
//   starve     out  head flit blocked for STARVE_LIMIT cycles
//   fifoCount  out  queue occupancy
// ---------------------------------------------------------------------------

`ifndef WIDTH_DATA
`define WIDTH_DATA 32
`endif
`ifndef WIDTH_PORT
`define WIDTH_PORT (`WIDTH_DATA + 24)
`endif

module bless_inject_ctrl #(
    parameter int WIDTH_PORT   = `WIDTH_PORT,
    parameter int FIFO_DEPTH   = 4,   // power of 2, at least 2
    parameter int STARVE_LIMIT = 16,
    parameter int INJ_GAP      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH_PORT-1:0]         coreFlit,
    input  logic                          coreValid,
    output logic                          coreReady,
    input  logic [WIDTH_PORT-1:0]         dinW,
    input  logic [WIDTH_PORT-1:0]         dinE,
    input  logic [WIDTH_PORT-1:0]         dinS,
    input  logic [WIDTH_PORT-1:0]         dinN,
    output logic [WIDTH_PORT-1:0]         dinLocal,
    output logic                          injFire,
    output logic                          starve,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam int WD        = WIDTH_PORT - 24;
    localparam int TIME_LO   = WD + 8;
    localparam int FLITID_LO = WD + 16;
    localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int BW        = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH_PORT-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic [7:0]            tstamp_q;
    logic [7:0]            pkt_stamp_q;
    logic [BW-1:0]         block_cnt_q, block_cnt_d;

    logic                  push, pop, elig;
    logic                  head_present, head_is_first, net_full;
    logic [WIDTH_PORT-1:0] head, stamped;

    // occ == 4 is the same as every network input carrying a flit.
    assign net_full      = (|dinW) & (|dinE) & (|dinS) & (|dinN);
    assign head_present  = (count_q != '0);
    assign head          = mem_q[rd_ptr_q];
    assign head_is_first = (head[FLITID_LO +: 2] == 2'd0);

    assign coreReady = (count_q != CW'(FIFO_DEPTH));
    // Zero words are idle slots on the router, so they are never queued.
    assign push      = coreValid & coreReady & (|coreFlit);
    assign elig      = head_present & ~net_full & (state_q != ST_HOLD);
    assign pop       = elig;

    assign dinLocal  = elig ? stamped : '0;
    assign injFire   = elig;
    assign starve    = (block_cnt_q == BW'(STARVE_LIMIT));
    assign fifoCount = count_q;

    // Body flits reuse the stamp of their packet's head flit so that the
    // whole packet competes with a single age.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        stamped = head;
        if (head_is_first) begin
            stamped[TIME_LO +: 8] = tstamp_q;
        end else begin
            stamped[TIME_LO +: 8] = pkt_stamp_q;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        block_cnt_d = block_cnt_q;
        if (pop) begin
            block_cnt_d = '0;
        end else if ((state_q == ST_WAIT) && net_full &&
                     (block_cnt_q != BW'(STARVE_LIMIT))) begin
            block_cnt_d = block_cnt_q + 1'b1;
        end
    end

`ifdef BLESS_THROTTLE_EN
    localparam int GW = (INJ_GAP > 1) ? $clog2(INJ_GAP) : 1;

    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          gap_done;

    // Counts HOLD cycles; it is zero whenever HOLD is entered because the
    // entering injection always happens from WAIT.
    assign gap_cnt_d = (state_q == ST_HOLD) ? gap_cnt_q + 1'b1 : '0;
    assign gap_done  = (gap_cnt_q == GW'(INJ_GAP - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end
`else
    logic unused_inj_gap;
    assign unused_inj_gap = (INJ_GAP != 0);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (pop) begin
`ifdef BLESS_THROTTLE_EN
                    if (INJ_GAP > 0) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = (count_d == '0) ? ST_EMPTY : ST_WAIT;
                    end
`else
                    state_d = (count_d == '0) ? ST_EMPTY : ST_WAIT;
`endif
                end
            end
            ST_HOLD: begin
`ifdef BLESS_THROTTLE_EN
                if (gap_done) begin
                    state_d = (count_d == '0) ? ST_EMPTY : ST_WAIT;
                end
`else
                state_d = (count_d == '0) ? ST_EMPTY : ST_WAIT;
`endif
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // NOTE: queue storage has no reset; the pointers and count define which
    // entries are valid, so a flush only needs to clear those.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= coreFlit;
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state updates use non-blocking assignments so all registers
        // see the same pre-edge values.
        if (reset) begin
            state_q     <= ST_EMPTY;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tstamp_q    <= '0;
            pkt_stamp_q <= '0;
            block_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            tstamp_q    <= tstamp_q + 8'd1;
            block_cnt_q <= block_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (pop && head_is_first) pkt_stamp_q <= tstamp_q;
        end
    end

endmodule

// File: tb/tb_bless_inject_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bless_inject_ctrl
//
// Directed bench for bless_inject_ctrl. A queue of flits the core has handed
// over plus a running timestamp / packet-stamp model give the expected
// dinLocal, injFire and fifoCount for every cycle checked.
// ---------------------------------------------------------------------------

module tb_bless_inject_ctrl;

    localparam int WD = 32;
    localparam int WP = WD + 24;
`ifdef BLESS_THROTTLE_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 0;
`endif

    localparam logic [WP-1:0] NZ_W = WP'(64'h0000_0000_0000_0011);
    localparam logic [WP-1:0] NZ_E = WP'(64'h0000_0000_0000_0022);
    localparam logic [WP-1:0] NZ_S = WP'(64'h0000_0000_0000_0033);
    localparam logic [WP-1:0] NZ_N = WP'(64'h0000_0000_0000_0044);

    logic          clk = 1'b0;
    logic          reset;
    logic [WP-1:0] coreFlit;
    logic          coreValid;
    logic          coreReady;
    logic [WP-1:0] dinW, dinE, dinS, dinN;
    logic [WP-1:0] dinLocal;
    logic          injFire;
    logic          starve;
    logic [2:0]    fifoCount;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [7:0]    exp_ts;
    logic [7:0]    exp_pkt;
    logic [WP-1:0] q[$];
    logic [WP-1:0] flits[4];

    bless_inject_ctrl #(.WIDTH_PORT(WP)) dut (
        .clk       (clk),
        .reset     (reset),
        .coreFlit  (coreFlit),
        .coreValid (coreValid),
        .coreReady (coreReady),
        .dinW      (dinW),
        .dinE      (dinE),
        .dinS      (dinS),
        .dinN      (dinN),
        .dinLocal  (dinLocal),
        .injFire   (injFire),
        .starve    (starve),
        .fifoCount (fifoCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WP-1:0] got, input logic [WP-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [WP-1:0] mk(input logic [5:0] pid, input logic [1:0] fid, input logic [WD-1:0] data);
        return {pid, fid, 8'hA5, 4'h3, 4'h7, data};
    endfunction

    function automatic logic [WP-1:0] stamp(input logic [WP-1:0] f, input logic [7:0] t);
        logic [WP-1:0] r;
        r = f;
        r[WD+8 +: 8] = t;
        return r;
    endfunction

    function automatic bit inj_at(input int i, input int first, input int n);
        return (i >= first) && (((i - first) % (GAP + 1)) == 0) && (((i - first) / (GAP + 1)) < n);
    endfunction

    task automatic tick();
        @(posedge clk);
        exp_ts = exp_ts + 8'd1;
        #1;
    endtask

    task automatic set_occ(input int n);
        dinW = (n >= 1) ? NZ_W : '0;
        dinS = (n >= 2) ? NZ_S : '0;
        dinE = (n >= 3) ? NZ_E : '0;
        dinN = (n >= 4) ? NZ_N : '0;
    endtask

    // Compares occupancy and the local output against the model for the
    // current cycle; on an expected injection the model queue head leaves.
    task automatic cycle_check(input string tag, input bit exp_inj);
        logic [WP-1:0] f;
        logic [7:0]    t;
        check({tag, ".cnt"}, WP'(fifoCount), WP'(q.size()));
        check({tag, ".inj"}, WP'(injFire), WP'(exp_inj));
        if (exp_inj && q.size() > 0) begin
            f = q.pop_front();
            t = (f[WD+16 +: 2] == 2'd0) ? exp_ts : exp_pkt;
            if (f[WD+16 +: 2] == 2'd0) exp_pkt = t;
            check({tag, ".dl"}, dinLocal, stamp(f, t));
        end else begin
            check({tag, ".dl"}, dinLocal, '0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        coreFlit  = '0;
        coreValid = 1'b0;
        set_occ(0);
        exp_ts    = '0;
        exp_pkt   = '0;
        repeat (2) @(posedge clk);
        #2;

        // ---- reset values
        check("rst.dl",    dinLocal, '0);
        check("rst.inj",   WP'(injFire), '0);
        check("rst.starve",WP'(starve), '0);
        check("rst.cnt",   WP'(fifoCount), '0);
        check("rst.ready", WP'(coreReady), WP'(1));
        reset  = 1'b0;
        exp_ts = '0;
        tick();

        // ---- all-zero core word is dropped
        coreValid = 1'b1;
        coreFlit  = '0;
        tick();
        coreValid = 1'b0;
        check("zero.cnt", WP'(fifoCount), '0);

        // ---- single flit pushed at tstamp 5, injected with TIME 6
        for (int k = 0; k < 300 && exp_ts != 8'd5; k++) tick();
        check("t1.ts", WP'(exp_ts), WP'(5));
        flits[0]  = mk(6'd1, 2'd0, 32'hAAAA_0001);
        coreFlit  = flits[0];
        coreValid = 1'b1;
        #1;
        cycle_check("t1.push", 1'b0);
        q.push_back(flits[0]);
        tick();
        coreValid = 1'b0;
        #1;
        check("t1.time", WP'(dinLocal[WD+8 +: 8]), WP'(6));
        cycle_check("t1.inj", 1'b1);
        tick();
        cycle_check("t1.after", 1'b0);
        repeat (4) tick();

        // ---- starvation with occ = 4
        set_occ(4);
        flits[0]  = mk(6'd2, 2'd0, 32'hBBBB_0002);
        coreFlit  = flits[0];
        coreValid = 1'b1;
        q.push_back(flits[0]);
        tick();
        coreValid = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            #1;
            if (j == 1)  cycle_check("t2.blk1", 1'b0);
            if (j == 15) check("t2.starve15", WP'(starve), '0);
            if (j == 17) check("t2.starve17", WP'(starve), WP'(1));
            if (j == 20) begin
                check("t2.starve20", WP'(starve), WP'(1));
                cycle_check("t2.blk20", 1'b0);
            end
            tick();
        end
        dinN = '0;
        #1;
        check("t2.starve_inj", WP'(starve), WP'(1));
        cycle_check("t2.release", 1'b1);
        tick();
        check("t2.starve_clr", WP'(starve), '0);
        cycle_check("t2.after", 1'b0);
        repeat (4) tick();

        // ---- packet of four flits across the timestamp wrap, occ = 3
        set_occ(3);
        for (int k = 0; k < 300 && exp_ts != 8'd253; k++) tick();
        check("t3.ts", WP'(exp_ts), WP'(253));
        for (int i = 0; i < 4; i++) flits[i] = mk(6'd5, 2'(i), 32'hCCCC_0000 + 32'(i));
        for (int i = 0; i < 3 * (GAP + 1) + 3; i++) begin
            if (i < 4) begin
                coreValid = 1'b1;
                coreFlit  = flits[i];
            end else begin
                coreValid = 1'b0;
            end
            #1;
            cycle_check($sformatf("t3.c%0d", i), inj_at(i, 1, 4));
            if (i < 4) q.push_back(flits[i]);
            tick();
        end
        coreValid = 1'b0;
        repeat (4) tick();

        // ---- fill the FIFO while blocked, then drain with occ = 2
        set_occ(4);
        for (int i = 0; i < 4; i++) flits[i] = mk(6'd7, 2'd0, 32'hDDDD_0000 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            coreValid = 1'b1;
            coreFlit  = flits[i];
            #1;
            check($sformatf("t4.rdy%0d", i), WP'(coreReady), WP'(1));
            q.push_back(flits[i]);
            tick();
        end
        coreFlit = mk(6'd9, 2'd0, 32'hEEEE_EEEE);
        #1;
        check("t4.full.cnt", WP'(fifoCount), WP'(4));
        check("t4.full.rdy", WP'(coreReady), '0);
        tick();
        coreValid = 1'b0;
        check("t4.full.hold", WP'(fifoCount), WP'(4));
        set_occ(2);
        for (int j = 0; j < 3 * (GAP + 1) + 3; j++) begin
            #1;
            if (j == 1) check("t4.rdy_after_pop", WP'(coreReady), WP'(1));
            cycle_check($sformatf("t4.d%0d", j), inj_at(j, 0, 4));
            tick();
        end
        repeat (4) tick();

        // ---- injection spacing with three queued flits, occ = 0
        set_occ(4);
        for (int i = 0; i < 3; i++) begin
            flits[i]  = mk(6'd11, 2'd0, 32'h5555_0000 + 32'(i));
            coreValid = 1'b1;
            coreFlit  = flits[i];
            q.push_back(flits[i]);
            tick();
        end
        coreValid = 1'b0;
        set_occ(0);
        for (int j = 0; j < 8; j++) begin
            #1;
            cycle_check($sformatf("t5.c%0d", j), inj_at(j, 0, 3));
            tick();
        end
        repeat (4) tick();

        // ---- reset mid-operation with two flits queued
        set_occ(4);
        for (int i = 0; i < 2; i++) begin
            coreValid = 1'b1;
            coreFlit  = mk(6'd13, 2'd0, 32'h7777_0000 + 32'(i));
            tick();
        end
        coreValid = 1'b0;
        set_occ(0);
        #1;
        check("t6.pre.inj", WP'(injFire), WP'(1));
        check("t6.pre.cnt", WP'(fifoCount), WP'(2));
        #1;
        reset = 1'b1;
        #1;
        check("t6.rst.cnt", WP'(fifoCount), '0);
        check("t6.rst.dl",  dinLocal, '0);
        check("t6.rst.inj", WP'(injFire), '0);
        check("t6.rst.rdy", WP'(coreReady), WP'(1));
        #1;
        reset   = 1'b0;
        exp_ts  = '0;
        exp_pkt = '0;
        q.delete();

        // ---- body flit right after reset uses the cleared packet stamp
        flits[0]  = mk(6'd14, 2'd1, 32'h9999_0001);
        coreFlit  = flits[0];
        coreValid = 1'b1;
        q.push_back(flits[0]);
        tick();
        coreValid = 1'b0;
        #1;
        cycle_check("t7.body", 1'b1);
        tick();
        cycle_check("t7.after", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
